// File: rtl/myvga_timing_gen.sv
// VGA pixel timing and colour-pattern stage fed by the axi_myVGA register file.
// Configuration is shadowed at each frame start so register writes never tear a frame.
module myvga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_pix_ce,
    input  logic [31:0]      i_cfg_ctrl,
    input  logic [31:0]      i_cfg_fg,
    input  logic [31:0]      i_cfg_bg,
    input  logic [31:0]      i_cfg_bar_w,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [3:0]       o_vga_r,
    output logic [3:0]       o_vga_g,
    output logic [3:0]       o_vga_b,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_frame_start,
    output logic [15:0]      o_frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_S = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_E = H_SYNC_S + H_SYNC;
    localparam int unsigned V_SYNC_S = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_E = V_SYNC_S + V_SYNC;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [CNT_W-1:0] r_bar_cnt;
    logic             r_bar_sel;
    logic             r_mode;
    logic [11:0]      r_fg;
    logic [11:0]      r_bg;
    logic [CNT_W-1:0] r_bar_w;
    logic             r_fs_evt;
    logic             r_ce_d;

    logic             w_en;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_start;
    logic [CNT_W-1:0] w_bar_lim;
    logic             w_bar_last;
    logic             w_de;
    logic             w_hs_act;
    logic             w_vs_act;
    logic [11:0]      w_rgb;
    logic             w_unused;

    assign w_unused = ^{i_cfg_ctrl[31:2], i_cfg_fg[31:12], i_cfg_bg[31:12], i_cfg_bar_w[31:CNT_W]};

    // Pixel decode of the current counter state; a bar width of 0 behaves as 1.
    always_comb begin
        w_en       = i_cfg_ctrl[0];
        w_h_last   = (r_h == CNT_W'(H_TOTAL - 1));
        w_v_last   = (r_v == CNT_W'(V_TOTAL - 1));
        w_start    = i_pix_ce && w_en && ((r_state == S_IDLE) || (w_h_last && w_v_last));
        w_bar_lim  = (r_bar_w == '0) ? '0 : r_bar_w - CNT_W'(1);
        w_bar_last = (r_bar_cnt == w_bar_lim);
        w_de       = (32'(r_h) < H_ACTIVE) && (32'(r_v) < V_ACTIVE);
        w_hs_act   = (32'(r_h) >= H_SYNC_S) && (32'(r_h) < H_SYNC_E);
        w_vs_act   = (32'(r_v) >= V_SYNC_S) && (32'(r_v) < V_SYNC_E);
        w_rgb      = (r_mode && r_bar_sel) ? r_bg : r_fg;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_h           <= '0;
            r_v           <= '0;
            r_bar_cnt     <= '0;
            r_bar_sel     <= 1'b0;
            r_mode        <= 1'b0;
            r_fg          <= 12'h000;
            r_bg          <= 12'h000;
            r_bar_w       <= '0;
            r_fs_evt      <= 1'b0;
            r_ce_d        <= 1'b0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_vga_r       <= 4'h0;
            o_vga_g       <= 4'h0;
            o_vga_b       <= 4'h0;
            o_h_cnt       <= '0;
            o_v_cnt       <= '0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= 16'h0000;
        end else begin
            r_ce_d        <= i_pix_ce;
            r_fs_evt      <= w_start;
            o_frame_start <= r_fs_evt;
            if (r_fs_evt) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end

            if (w_start) begin
                r_mode  <= i_cfg_ctrl[1];
                r_fg    <= i_cfg_fg[11:0];
                r_bg    <= i_cfg_bg[11:0];
                r_bar_w <= i_cfg_bar_w[CNT_W-1:0];
            end

            // Counter FSM; in IDLE the counters already sit at (0,0).
            if (i_pix_ce) begin
                if (r_state == S_IDLE) begin
                    if (w_en) begin
                        r_state <= S_RUN;
                    end
                end else if (w_h_last) begin
                    r_h       <= '0;
                    r_bar_cnt <= '0;
                    r_bar_sel <= 1'b0;
                    if (w_v_last) begin
                        r_v <= '0;
                        if (!w_en) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_v <= r_v + CNT_W'(1);
                    end
                end else begin
                    r_h <= r_h + CNT_W'(1);
                    if (w_bar_last) begin
                        r_bar_cnt <= '0;
                        r_bar_sel <= ~r_bar_sel;
                    end else begin
                        r_bar_cnt <= r_bar_cnt + CNT_W'(1);
                    end
                end
            end

            // Output stage follows the counters one clock after each pixel step.
            if (r_ce_d) begin
                if (r_state == S_RUN) begin
                    o_de                        <= w_de;
                    o_hsync                     <= w_hs_act ? SYNC_POL : ~SYNC_POL;
                    o_vsync                     <= w_vs_act ? SYNC_POL : ~SYNC_POL;
                    {o_vga_r, o_vga_g, o_vga_b} <= w_de ? w_rgb : 12'h000;
                    o_h_cnt                     <= r_h;
                    o_v_cnt                     <= r_v;
                end else begin
                    o_de                        <= 1'b0;
                    o_hsync                     <= ~SYNC_POL;
                    o_vsync                     <= ~SYNC_POL;
                    {o_vga_r, o_vga_g, o_vga_b} <= 12'h000;
                    o_h_cnt                     <= '0;
                    o_v_cnt                     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_myvga_timing_gen.sv
// Directed bench for myvga_timing_gen using a 14x7 total raster and pix_ce every 2nd clock.
module tb_myvga_timing_gen;

    localparam int unsigned HA = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 2;
    localparam int unsigned HB = 2;
    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 1;
    localparam int unsigned VB = 1;
    localparam int unsigned CW = 4;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME_CLK = HT * VT * 2;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          ce   = 1'b0;
    logic [31:0]   ctrl = 32'h0;
    logic [31:0]   fg   = 32'h0;
    logic [31:0]   bg   = 32'h0;
    logic [31:0]   barw = 32'h0;

    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;
    logic [3:0]    o_vga_r;
    logic [3:0]    o_vga_g;
    logic [3:0]    o_vga_b;
    logic [CW-1:0] o_h_cnt;
    logic [CW-1:0] o_v_cnt;
    logic          o_frame_start;
    logic [15:0]   o_frame_cnt;
    logic [11:0]   rgb;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned clk_cnt  = 0;
    int unsigned fs_count = 0;
    int unsigned fs_last_clk = 0;
    int unsigned fs_prev_clk = 0;
    int unsigned eh = 0;
    int unsigned ev = 0;

    assign rgb = {o_vga_r, o_vga_g, o_vga_b};

    myvga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .CNT_W(CW)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_pix_ce(ce),
        .i_cfg_ctrl(ctrl), .i_cfg_fg(fg), .i_cfg_bg(bg), .i_cfg_bar_w(barw),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
        .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
        .o_h_cnt(o_h_cnt), .o_v_cnt(o_v_cnt),
        .o_frame_start(o_frame_start), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) clk_cnt++;

    always @(negedge clk) begin
        if (o_frame_start === 1'b1) begin
            fs_count++;
            fs_prev_clk = fs_last_clk;
            fs_last_clk = clk_cnt;
        end
    end

    // One pixel: pix_ce high for one clock then low for one; returns just after the output update.
    task automatic pix();
        @(negedge clk) ce = 1'b1;
        @(posedge clk);
        @(negedge clk) ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        pix();
        if (eh == HT - 1) begin
            eh = 0;
            ev = (ev == VT - 1) ? 0 : ev + 1;
        end else begin
            eh++;
        end
    endtask

    task automatic run_to(input int unsigned h, input int unsigned v);
        for (int unsigned i = 0; i < HT * VT; i++) begin
            if (eh == h && ev == v) break;
            adv();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ctrl = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (50) pix();
        n_checks++; if (o_hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", o_hsync); end
        n_checks++; if (o_vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", o_vsync); end
        n_checks++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", o_de); end
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb); end
        n_checks++; if (o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", o_frame_cnt); end
        n_checks++; if (fs_count != 0 || o_frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: seen %0d want 0", fs_count); end
        n_checks++; if (o_h_cnt !== 4'd0 || o_v_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got (%0d,%0d) want (0,0)", o_h_cnt, o_v_cnt); end
    endtask

    task automatic test_mode0();
        logic        e_de;
        logic        e_hs;
        logic        e_vs;
        logic [11:0] e_rgb;
        fg = 32'h0000_0F0A; bg = 32'h0; barw = 32'h0; ctrl = 32'h1;
        pix();
        eh = 0; ev = 0;
        n_checks++; if (o_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL m0_frame_cnt1: got %0d want 1", o_frame_cnt); end
        for (int unsigned p = 0; p < HT * VT; p++) begin
            e_de  = (eh < HA) && (ev < VA);
            e_hs  = !((eh >= HA + HF) && (eh < HA + HF + HS));
            e_vs  = !(ev == VA + VF);
            e_rgb = e_de ? 12'hF0A : 12'h000;
            n_checks++; if (o_h_cnt !== 4'(eh) || o_v_cnt !== 4'(ev)) begin n_fail++; $display("FAIL m0_cnt: got (%0d,%0d) want (%0d,%0d)", o_h_cnt, o_v_cnt, eh, ev); end
            n_checks++; if (o_de !== e_de) begin n_fail++; $display("FAIL m0_de (%0d,%0d): got %b want %b", eh, ev, o_de, e_de); end
            n_checks++; if (o_hsync !== e_hs) begin n_fail++; $display("FAIL m0_hsync (%0d,%0d): got %b want %b", eh, ev, o_hsync, e_hs); end
            n_checks++; if (o_vsync !== e_vs) begin n_fail++; $display("FAIL m0_vsync (%0d,%0d): got %b want %b", eh, ev, o_vsync, e_vs); end
            n_checks++; if (rgb !== e_rgb) begin n_fail++; $display("FAIL m0_rgb (%0d,%0d): got %h want %h", eh, ev, rgb, e_rgb); end
            n_checks++; if (o_frame_start !== (p == 0)) begin n_fail++; $display("FAIL m0_frame_start (%0d,%0d): got %b want %b", eh, ev, o_frame_start, (p == 0)); end
            if (p == 1) begin
                n_checks++; if (fs_count != 1) begin n_fail++; $display("FAIL m0_fs_once: seen %0d want 1", fs_count); end
            end
            adv();
        end
        n_checks++; if (o_frame_start !== 1'b1 || o_frame_cnt !== 16'd2) begin n_fail++; $display("FAIL m0_wrap: fs %b cnt %0d want 1/2", o_frame_start, o_frame_cnt); end
        adv();
        n_checks++; if (fs_count != 2) begin n_fail++; $display("FAIL m0_fs_count: seen %0d want 2", fs_count); end
        n_checks++; if (fs_last_clk - fs_prev_clk != FRAME_CLK) begin n_fail++; $display("FAIL m0_fs_period: got %0d clk want %0d", fs_last_clk - fs_prev_clk, FRAME_CLK); end
    endtask

    task automatic test_mid_frame_write();
        logic [11:0] e_rgb;
        run_to(3, 1);
        fg = 32'h0000_00F0;
        for (int unsigned i = 0; i < HT * VT; i++) begin
            if (eh == 0 && ev == 0) break;
            e_rgb = ((eh < HA) && (ev < VA)) ? 12'hF0A : 12'h000;
            n_checks++; if (rgb !== e_rgb) begin n_fail++; $display("FAIL mw_rgb (%0d,%0d): got %h want %h", eh, ev, rgb, e_rgb); end
            adv();
        end
        n_checks++; if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL mw_next_frame: got %h want 0F0", rgb); end
        n_checks++; if (o_frame_cnt !== 16'd3) begin n_fail++; $display("FAIL mw_frame_cnt: got %0d want 3", o_frame_cnt); end
    endtask

    task automatic test_bars();
        logic [7:0]  bar3;
        logic [11:0] e_rgb;
        bar3 = 8'b0011_1000;
        ctrl = 32'h3; fg = 32'h0000_000F; bg = 32'h0000_0F00; barw = 32'd3;
        adv();
        n_checks++; if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL bar_shadow: got %h want 0F0", rgb); end
        run_to(0, 0);
        for (int unsigned h = 0; h < HA; h++) begin
            e_rgb = bar3[h] ? 12'hF00 : 12'h00F;
            n_checks++; if (rgb !== e_rgb) begin n_fail++; $display("FAIL bar3_rgb h=%0d: got %h want %h", h, rgb, e_rgb); end
            adv();
        end
        n_checks++; if (rgb !== 12'h000 || o_de !== 1'b0) begin n_fail++; $display("FAIL bar3_blank: got %h de %b want 000 de 0", rgb, o_de); end
        barw = 32'd0;
        run_to(0, 0);
        for (int unsigned v = 0; v < 2; v++) begin
            run_to(0, v);
            for (int unsigned h = 0; h < HA; h++) begin
                e_rgb = h[0] ? 12'hF00 : 12'h00F;
                n_checks++; if (rgb !== e_rgb) begin n_fail++; $display("FAIL bar0_rgb (%0d,%0d): got %h want %h", h, v, rgb, e_rgb); end
                adv();
            end
        end
    endtask

    task automatic test_disable();
        int unsigned base_fs;
        logic [15:0] base_fc;
        run_to(HT - 1, VT - 1);
        base_fs = fs_count;
        base_fc = o_frame_cnt;
        adv();
        run_to(2, 2);
        ctrl = 32'h2;
        run_to(HT - 1, VT - 1);
        n_checks++; if (o_h_cnt !== 4'(HT - 1) || o_v_cnt !== 4'(VT - 1)) begin n_fail++; $display("FAIL dis_last_pixel: got (%0d,%0d) want (13,6)", o_h_cnt, o_v_cnt); end
        pix();
        eh = 0; ev = 0;
        n_checks++; if (o_de !== 1'b0 || rgb !== 12'h000) begin n_fail++; $display("FAIL dis_idle_video: de %b rgb %h want 0/000", o_de, rgb); end
        n_checks++; if (o_hsync !== 1'b1 || o_vsync !== 1'b1) begin n_fail++; $display("FAIL dis_idle_sync: hs %b vs %b want 1/1", o_hsync, o_vsync); end
        repeat (20) pix();
        n_checks++; if (o_h_cnt !== 4'd0 || o_v_cnt !== 4'd0) begin n_fail++; $display("FAIL dis_idle_cnt: got (%0d,%0d) want (0,0)", o_h_cnt, o_v_cnt); end
        n_checks++; if (fs_count - base_fs != 1) begin n_fail++; $display("FAIL dis_fs_count: seen %0d want 1", fs_count - base_fs); end
        n_checks++; if (o_frame_cnt !== base_fc + 16'd1) begin n_fail++; $display("FAIL dis_frame_cnt: got %0d want %0d", o_frame_cnt, base_fc + 16'd1); end
    endtask

    task automatic test_freeze_and_reset();
        ctrl = 32'h1; fg = 32'h0000_00F0;
        pix();
        eh = 0; ev = 0;
        run_to(3, 2);
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (o_h_cnt !== 4'd3 || o_v_cnt !== 4'd2) begin n_fail++; $display("FAIL frz_cnt: got (%0d,%0d) want (3,2)", o_h_cnt, o_v_cnt); end
        n_checks++; if (o_de !== 1'b1 || rgb !== 12'h0F0) begin n_fail++; $display("FAIL frz_video: de %b rgb %h want 1/0F0", o_de, rgb); end
        n_checks++; if (o_frame_start !== 1'b0 || o_hsync !== 1'b1) begin n_fail++; $display("FAIL frz_ctl: fs %b hs %b want 0/1", o_frame_start, o_hsync); end
        adv();
        n_checks++; if (o_h_cnt !== 4'd4) begin n_fail++; $display("FAIL frz_resume: got %0d want 4", o_h_cnt); end
        adv();
        n_checks++; if (o_frame_cnt !== 16'd7) begin n_fail++; $display("FAIL rst_pre_frame_cnt: got %0d want 7", o_frame_cnt); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (o_h_cnt !== 4'd0 || o_v_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got (%0d,%0d) want (0,0)", o_h_cnt, o_v_cnt); end
        n_checks++; if (o_de !== 1'b0 || rgb !== 12'h000) begin n_fail++; $display("FAIL rst_video: de %b rgb %h want 0/000", o_de, rgb); end
        n_checks++; if (o_hsync !== 1'b1 || o_vsync !== 1'b1) begin n_fail++; $display("FAIL rst_sync: hs %b vs %b want 1/1", o_hsync, o_vsync); end
        n_checks++; if (o_frame_cnt !== 16'd0 || o_frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame: cnt %0d fs %b want 0/0", o_frame_cnt, o_frame_start); end
        @(negedge clk) begin rst = 1'b0; ctrl = 32'h0; end
        repeat (4) pix();
        n_checks++; if (o_de !== 1'b0 || o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_idle: de %b cnt %0d want 0/0", o_de, o_frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mid_frame_write();
        test_bars();
        test_disable();
        test_freeze_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
